// File: rtl/fetch_pkg.sv
// Shared widths, FSM encoding and buffer entry layout for the instruction fetch stage.
package fetch_pkg;
  localparam int INSTR_W = 20;
  localparam int ADDR_W  = 16;
  localparam int OPC_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch buffer: circular storage with combinational head read and flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output fetch_entry_t     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same edge, so push into a full buffer is legal then.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[head];

  always_ff @(posedge Clock) begin
    if (Reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= bump(tail);
      if (do_pop)  head <= bump(head);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push && !Reset && !flush) mem[tail] <= din;
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues reads into a one-cycle memory, buffers responses, handles redirects.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                DEPTH    = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  MemAddr,
  output logic               MemRd,
  input  logic [INSTR_W-1:0] MemData,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectPC,
  input  logic               Stall,
  output logic [INSTR_W-1:0] InstrOut,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic               InstrValid,
  output fetch_state_t       DbgState
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Handshake: decode consumes the head when InstrValid=1 and Stall=0 in the same cycle.
  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              discard;
  logic              issue;
  logic              pop;
  logic              push;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ST_IDLE:  state_nxt = ST_RUN;
      ST_RUN: begin
        if (Redirect) state_nxt = ST_FLUSH;
        // Reserve a slot for every read already in flight, net of this cycle's pop.
        issue = ~Redirect & ~(full & ~pop) &
                ((int'(count) + int'(inflight)) < (DEPTH + int'(pop)));
      end
      ST_FLUSH: state_nxt = Redirect ? ST_FLUSH : ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign DbgState   = state;
  assign MemRd      = issue & ~Reset;
  assign MemAddr    = pc;
  assign InstrValid = ~empty & ~Reset;
  assign pop        = InstrValid & ~Stall;
  assign push       = inflight & ~discard;
  assign InstrOut   = InstrValid ? head.instr : '0;
  assign InstrPC    = InstrValid ? head.pc : '0;
  assign push_entry = '{pc: inflight_pc, instr: MemData};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      discard     <= 1'b0;
    end else begin
      inflight <= MemRd;
      // Any response landing in the cycle after a redirect belongs to the old stream.
      discard  <= Redirect;
      if (MemRd) inflight_pc <= pc;
      if (Redirect)   pc <= RedirectPC;
      else if (MemRd) pc <= pc + ADDR_W'(1);
    end
  end

  // Redirect drives flush, which the buffer gives priority over push and pop.
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .flush (Redirect),
    .din   (push_entry),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of prefetch buffer entries (legal values 2..4).
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 MemAddr  output  16  instruction memory read address.
REQ-006 MemRd  output  1  read strobe; memory returns MemData exactly one cycle later.
REQ-007 MemData  input  20  instruction word, valid in the cycle after MemRd.
REQ-008 Redirect  input  1  downstream request to restart fetch at RedirectPC.
REQ-009 RedirectPC  input  16  new fetch address, sampled when Redirect=1.
REQ-010 Stall  input  1  decode not ready; holds the presented instruction.
REQ-011 InstrOut  output  20  instruction presented to decode (opcode in [19:16]).
REQ-012 InstrPC  output  16  address of InstrOut.
REQ-013 InstrValid  output  1  InstrOut/InstrPC are valid.

Function
REQ-014 FSM states SHALL be IDLE, RUN and FLUSH.
REQ-015 FSM transitions SHALL be: IDLE->RUN unconditionally after one cycle; RUN->FLUSH on Redirect; FLUSH->RUN after one cycle; FLUSH->FLUSH on a further Redirect.
REQ-016 MemRd SHALL be 1 only in RUN, with Redirect=0 and (count + inflight - pop) < DEPTH, where pop = InstrValid & ~Stall.
REQ-017 On each issued read, MemAddr SHALL equal fetch PC, and fetch PC SHALL increment by 1 modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-018 The returning MemData and its address SHALL be pushed into the buffer the cycle after issue, unless the response is marked discard.
REQ-019 InstrValid SHALL be 1 whenever count > 0, with InstrOut/InstrPC taken from the buffer head (combinational read).
REQ-020 The head SHALL be popped only when InstrValid=1 and Stall=0.
REQ-021 When a pop and a push occur in the same cycle, count SHALL be unchanged and order SHALL be preserved.
REQ-022 Under sustained Stall=0 with no Redirect, the block SHALL deliver one instruction per cycle from the third cycle after reset release.
REQ-023 While Stall=1 the head SHALL remain stable, and the buffer SHALL never overflow.
REQ-024 On Redirect, in the same edge:
  - the buffer SHALL be emptied;
  - an in-flight response SHALL be marked discard;
  - fetch PC SHALL be loaded with RedirectPC;
  - no MemRd SHALL issue that cycle.
REQ-025 Redirect SHALL take priority over Stall and pop.
REQ-026 InstrValid SHALL be 0 in the cycle after Redirect.
REQ-027 A discarded response SHALL never reach InstrOut.
REQ-028 In FLUSH, the first MemRd SHALL issue at RedirectPC.

Reset
REQ-029 On Reset=1 at a rising edge:
  - FSM SHALL go to IDLE;
  - fetch PC SHALL be loaded with RESET_PC;
  - count, inflight and discard SHALL be set to 0;
  - head/tail pointers SHALL be set to 0.
REQ-030 While in reset and in IDLE, outputs SHALL be MemRd=0, MemAddr=RESET_PC, InstrValid=0, InstrOut=0, InstrPC=0.
REQ-031 Reset asserted mid-operation SHALL override Redirect and SHALL drop all buffered and in-flight instructions.

Structure
REQ-032 Package fetch_pkg SHALL hold INSTR_W=20, ADDR_W=16, OPC_W=4 and the FSM state encoding.
REQ-033 The buffer SHALL be a sub-module fetch_fifo (parameter DEPTH; push/pop/flush; count; full/empty), instantiated once.
REQ-034 The block SHALL contain no latches, and every output SHALL be driven in every state.

Verification
REQ-035 Reset release, memory word[i] = 20'hA0000+i, Stall=0: MemAddr 0,1,2...; InstrValid from cycle 3; InstrPC 0,1,2 on consecutive cycles.
REQ-036 Stall=1 for 5 cycles at InstrPC=4: InstrOut holds word[4]; count never exceeds DEPTH; MemRd=0 once full; resume yields 4,5,6 with no gaps or duplicates.
REQ-037 Redirect=1, RedirectPC=16'h0100, while a read is in flight: next cycle InstrValid=0; next MemAddr=16'h0100; first valid InstrPC=16'h0100; the stale word never appears.
REQ-038 Redirect asserted together with Stall=1 and a full buffer: buffer empties; Stall ignored; fetch restarts at RedirectPC.
REQ-039 RedirectPC=16'hFFFE with free run: InstrPC FFFE, FFFF, 0000, 0001.
REQ-040 Reset asserted mid-stream with Redirect=1: all outputs take reset values; fetch restarts at RESET_PC.
